// File: rtl/ring_fifo.sv
// Single-clock circular-buffer FIFO with registered 1-cycle read, status flags and data count.
// Define RING_FIFO_ERROR_FLAGS_EN to build the sticky overflow/underflow registers.
module ring_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int FIFO_DEPTH         = 8,
  parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   data_count,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  active, pop_acc, push_acc;

  // clear only acts while enabled, so enable=0 freezes everything but out_valid
  assign active   = enable & ~clear;
  assign pop_acc  = active & pop & ~empty;
  assign push_acc = active & push & (~full | pop_acc);

  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(ALMOST_FULL_LEVEL));
  assign almost_empty = (count <= CW'(ALMOST_EMPTY_LEVEL));
  assign data_count   = count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (enable && clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= pop_acc;
      if (pop_acc) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage is not reset; a full push+pop reads the old word before it is overwritten
  always_ff @(posedge clock) begin
    if (push_acc) mem[wr_ptr] <= in_data;
  end

`ifdef RING_FIFO_ERROR_FLAGS_EN
  logic ov_evt, uf_evt;
  assign ov_evt = active & push & full & ~pop_acc;
  assign uf_evt = active & pop & empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (enable && clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ov_evt) overflow  <= 1'b1;
      if (uf_evt) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule
